// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with shift counter (optional parity: USR_PARITY_EN)
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done,
    output logic                       par
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             cnt_inc;
    logic             done_nxt;

    // Next register value and counter from the enabled operation; en=0 holds everything.
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        cnt_inc = 1'b0;
        if (en) begin
            case (mode)
                M_HOLD:  q_nxt = q;
                M_LOAD:  q_nxt = d;
                M_SHL:   begin q_nxt = {q[WIDTH-2:0], sin};      cnt_inc = 1'b1; end
                M_SHR:   begin q_nxt = {sin, q[WIDTH-1:1]};      cnt_inc = 1'b1; end
                M_ROL:   begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; cnt_inc = 1'b1; end
                M_ROR:   begin q_nxt = {q[0], q[WIDTH-1:1]};     cnt_inc = 1'b1; end
                M_ASR:   begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; cnt_inc = 1'b1; end
                M_CLEAR: q_nxt = RESET_VAL;
                default: q_nxt = q;
            endcase
            if (mode == M_LOAD || mode == M_CLEAR) begin
                cnt_nxt = '0;
            end else if (cnt_inc && cnt != CNT_MAX) begin
                cnt_nxt = cnt + CW'(1);
            end
        end
        done_nxt = (cnt_nxt == CNT_MAX);
    end

    // State registers; reset is asynchronous so q/cnt/done clear immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

    // Serial out taps the bit about to leave: MSB for left moves, LSB otherwise.
    assign sout = (en && (mode == M_SHL || mode == M_ROL)) ? q[WIDTH-1] : q[0];

`ifdef USR_PARITY_EN
    assign par = ^q;
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg (WIDTH=8)
module tb_universal_shift_reg;

    localparam int W = 8;

    localparam logic [2:0] HOLD  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHL   = 3'd2;
    localparam logic [2:0] SHR   = 3'd3;
    localparam logic [2:0] ROL   = 3'd4;
    localparam logic [2:0] ROR   = 3'd5;
    localparam logic [2:0] ASR   = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic         sout;
    logic [3:0]   cnt;
    logic         done;
    logic         par;

    int checks = 0;
    int errors = 0;

    // Reference state of the register
    int m_q   = 0;
    int m_cnt = 0;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q), .sout(sout), .cnt(cnt), .done(done), .par(par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_par(input int v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += (v >> i) & 1;
`ifdef USR_PARITY_EN
        return ones % 2;
`else
        return 0 * ones;
`endif
    endfunction

    function automatic int exp_sout();
        if (en === 1'b1 && (mode == SHL || mode == ROL)) return (m_q >> (W - 1)) & 1;
        return m_q & 1;
    endfunction

    // Advance the reference by one enabled operation using plain arithmetic.
    task automatic model_update(input logic e, input logic [2:0] m, input int dd, input int s);
        int msb;
        if (!e) return;
        msb = (m_q >> (W - 1)) & 1;
        case (m)
            LOAD:  begin m_q = dd; m_cnt = 0; end
            CLEAR: begin m_q = 0;  m_cnt = 0; end
            SHL:   m_q = ((m_q * 2) + s) % 256;
            SHR:   m_q = (m_q / 2) + s * 128;
            ROL:   m_q = ((m_q * 2) + msb) % 256;
            ROR:   m_q = (m_q / 2) + (m_q % 2) * 128;
            ASR:   m_q = (m_q / 2) + msb * 128;
            default: ;
        endcase
        if (m >= SHL && m <= ASR && m_cnt < W) m_cnt++;
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic s);
        en = e; mode = m; d = dd; sin = s;
        @(posedge clk);
        if (rst_n) model_update(e, m, int'(dd), int'(s));
        #1;
    endtask

    // Every falling edge: all outputs against the reference
    always @(negedge clk) begin
        chk("q", int'(q), m_q);
        chk("cnt", int'(cnt), m_cnt);
        chk("done", int'(done), (m_cnt == W) ? 1 : 0);
        chk("sout", int'(sout), exp_sout());
        chk("par", int'(par), exp_par(m_q));
    end

    initial begin
        logic [7:0] bits;
        rst_n = 1'b0; en = 1'b0; mode = HOLD; d = '0; sin = 1'b0;
        step(1'b1, LOAD, 8'hFF, 1'b0);
        step(1'b0, HOLD, 8'h00, 1'b0);
        chk("reset_q", int'(q), 0);
        rst_n = 1'b1;
        step(1'b0, HOLD, 8'h00, 1'b0);

        // async reset between edges with q=A5, cnt=3
        step(1'b1, LOAD, 8'h14, 1'b0);
        step(1'b1, SHL, 8'h00, 1'b1);
        step(1'b1, SHL, 8'h00, 1'b0);
        step(1'b1, SHL, 8'h00, 1'b1);
        chk("pre_rst_q", int'(q), 8'hA5);
        chk("pre_rst_cnt", int'(cnt), 3);
        #2;
        rst_n = 1'b0;
        m_q = 0; m_cnt = 0;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_cnt", int'(cnt), 0);
        chk("async_rst_done", int'(done), 0);
        step(1'b1, SHL, 8'h00, 1'b1);
        rst_n = 1'b1;

        // LOAD 81, SHL sin=1, ROR
        step(1'b1, LOAD, 8'h81, 1'b0);
        step(1'b1, SHL, 8'h00, 1'b1);
        chk("shl_q", int'(q), 8'h03);
        chk("shl_cnt", int'(cnt), 1);
        chk("shl_sout", int'(sout), 0);
        step(1'b1, ROR, 8'h00, 1'b0);
        chk("ror_q", int'(q), 8'h81);

        // LOAD B4, 8x SHR sin=0, then saturation
        step(1'b1, LOAD, 8'hB4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, SHR, 8'h00, 1'b0);
            chk("shr_not_done", int'(done), 0);
        end
        step(1'b1, SHR, 8'h00, 1'b0);
        chk("shr8_q", int'(q), 0);
        chk("shr8_cnt", int'(cnt), 8);
        chk("shr8_done", int'(done), 1);
        step(1'b1, SHR, 8'h00, 1'b1);
        chk("shr9_cnt", int'(cnt), 8);
        chk("shr9_done", int'(done), 1);
        chk("shr9_q", int'(q), 8'h80);
        step(1'b1, ROL, 8'h00, 1'b0);
        chk("rol_sat_q", int'(q), 8'h01);

        // ASR and enable gating
        step(1'b1, LOAD, 8'h80, 1'b0);
        step(1'b1, ASR, 8'h00, 1'b1);
        step(1'b1, ASR, 8'h00, 1'b0);
        step(1'b1, ASR, 8'h00, 1'b1);
        chk("asr_q", int'(q), 8'hF0);
        step(1'b0, LOAD, 8'h11, 1'b0);
        chk("en0_q", int'(q), 8'hF0);
        chk("en0_cnt", int'(cnt), 3);
        step(1'b0, SHL, 8'h11, 1'b0);
        chk("en0_sout", int'(sout), 0);

        // deserialize
        bits = 8'b10110010;
        step(1'b1, CLEAR, 8'h00, 1'b0);
        for (int i = 7; i >= 0; i--) step(1'b1, SHL, 8'h00, bits[i]);
        chk("deser_q", int'(q), 8'hB2);
        chk("deser_done", int'(done), 1);
        step(1'b1, CLEAR, 8'h00, 1'b0);
        chk("clear_q", int'(q), 0);
        chk("clear_cnt", int'(cnt), 0);
        chk("clear_done", int'(done), 0);

        // parity
        step(1'b1, LOAD, 8'h07, 1'b0);
`ifdef USR_PARITY_EN
        chk("par_07", int'(par), 1);
`else
        chk("par_07", int'(par), 0);
`endif
        step(1'b1, LOAD, 8'h03, 1'b0);
        chk("par_03", int'(par), 0);
        step(1'b1, HOLD, 8'h00, 1'b0);
        step(1'b0, HOLD, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
